// File: rtl/rand_gap_pkg.sv
// Shared definitions for the random gap timer: FSM state encoding,
// default widths and the saturating adder used to form the gap.
package rand_gap_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int MAX_EXP_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    COUNT = 2'd2
  } state_t;

  // Adds two zero-extended operands of 'width' bits. A sum that does not
  // fit in 'width' bits clamps to the all-ones value of that width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << width) - 33'd1;
    sat_add = (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/rand_gap_counter.sv
// Loadable down-counter holding the remaining gap. Clear beats load,
// load beats decrement. The zero flag is a decode of the count.
module rand_gap_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Count register with synchronous active-low reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rand_gap_timer.sv
// Random inter-event gap timer. On start it strobes the PRNG once, forms
// gap = sat(min_gap + (rnd & mask)), counts it down and pulses expire.
// Optional exponential backoff is enabled with macro RAND_EXP_BACKOFF_EN:
// retries widen the random mask by one bit each, up to MAX_EXP bits.
module rand_gap_timer
  import rand_gap_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_EXP = MAX_EXP_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             retry,
  input  logic             abort,
  input  logic [CNT_W-1:0] min_gap,
  input  logic [CNT_W-1:0] gap_mask,
  input  logic [31:0]      rnd_val,
  output logic             rnd_rd,
  output logic             busy,
  output logic             expire,
  output logic [CNT_W-1:0] cur_gap
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] eff_mask;
  logic [31:0]      gap_sum;
  logic [CNT_W-1:0] gap_val;
  logic             cnt_clear;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             expire_next;

  // Gap for this fetch: only the low CNT_W bits of the random word count.
  assign gap_sum = sat_add(32'(min_gap), 32'(rnd_val[CNT_W-1:0] & eff_mask), CNT_W);
  assign gap_val = gap_sum[CNT_W-1:0];

`ifdef RAND_EXP_BACKOFF_EN
  localparam logic [3:0]       MAX_ATT = 4'(MAX_EXP);
  localparam logic [CNT_W-1:0] ONE     = 1;

  logic [3:0] attempt;
  logic       unused_bits;

  // Backoff exponent: bumped on an accepted retry, cleared on a fresh start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      attempt <= '0;
    end else if (state == IDLE && start && !abort) begin
      if (retry) begin
        attempt <= (attempt >= MAX_ATT) ? MAX_ATT : attempt + 4'd1;
      end else begin
        attempt <= '0;
      end
    end
  end

  // Attempt is already updated by the time FETCH uses the mask.
  assign eff_mask    = (gap_mask << attempt) | ((ONE << attempt) - ONE);
  assign unused_bits = ^{rnd_val[31:CNT_W], gap_sum[31:CNT_W]};
`else
  logic unused_bits;

  assign eff_mask    = gap_mask;
  assign unused_bits = ^{rnd_val[31:CNT_W], gap_sum[31:CNT_W], retry};
`endif

  // State and registered expire pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      expire <= 1'b0;
    end else begin
      state  <= state_next;
      expire <= expire_next;
    end
  end

  // Next state, Moore outputs and counter controls; abort overrides all.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next  = state;
    rnd_rd      = 1'b0;
    busy        = 1'b0;
    cnt_clear   = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    expire_next = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        rnd_rd      = 1'b1;
        busy        = 1'b1;
        cnt_load    = 1'b1;
        expire_next = (gap_val == '0);
        state_next  = COUNT;
      end
      COUNT: begin
        busy        = 1'b1;
        cnt_dec     = !cnt_zero;
        expire_next = (cur_gap == CNT_W'(1));
        if (cnt_zero) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next  = IDLE;
      cnt_clear   = 1'b1;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      expire_next = 1'b0;
    end
  end

  rand_gap_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (gap_val),
    .count    (cur_gap),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_rand_gap_timer.sv
// Self-checking bench for rand_gap_timer. A timeline model predicts each
// cycle's outputs from when the fetch happened and how long the gap is.
// Honours RAND_EXP_BACKOFF_EN the same way the design does.
module tb_rand_gap_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        retry;
  logic        abort;
  logic [15:0] min_gap;
  logic [15:0] gap_mask;
  logic [31:0] rnd_val;
  logic        rnd_rd;
  logic        busy;
  logic        expire;
  logic [15:0] cur_gap;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a gap is a window starting at fetch cycle m_f, lasting m_g+1
  // counting cycles after it; expire lands on the window's last cycle.
  bit m_active  = 1'b0;
  int m_f       = 0;
  int m_g       = 0;
  int m_attempt = 0;

  rand_gap_timer #(.CNT_W(16), .MAX_EXP(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .retry    (retry),
    .abort    (abort),
    .min_gap  (min_gap),
    .gap_mask (gap_mask),
    .rnd_val  (rnd_val),
    .rnd_rd   (rnd_rd),
    .busy     (busy),
    .expire   (expire),
    .cur_gap  (cur_gap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_gap();
    int m;
    int s;
    m = int'(gap_mask);
`ifdef RAND_EXP_BACKOFF_EN
    m = ((int'(gap_mask) << m_attempt) | ((1 << m_attempt) - 1)) & 32'hFFFF;
`endif
    s = int'(min_gap) + (int'(rnd_val[15:0]) & m);
    return (s > 65535) ? 65535 : s;
  endfunction

  // Advance one clock: update the model with the inputs the edge samples,
  // then compare all outputs against the model's prediction.
  task automatic tick();
    int nc;
    bit e_rd;
    bit e_busy;
    bit e_exp;
    int e_gap;
    nc = cyc + 1;
    if (!reset_n) begin
      m_active  = 1'b0;
      m_attempt = 0;
    end else if (abort) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_f      = nc;
        m_attempt = retry ? ((m_attempt + 1 > 8) ? 8 : m_attempt + 1) : 0;
      end
    end else if (cyc == m_f) begin
      m_g = model_gap();
    end else if (cyc == m_f + 1 + m_g) begin
      m_active = 1'b0;
    end
    @(posedge clk);
    cyc = nc;
    #1;
    e_rd = 0; e_busy = 0; e_exp = 0; e_gap = 0;
    if (m_active) begin
      e_busy = 1;
      if (cyc == m_f) begin
        e_rd = 1;
      end else begin
        e_gap = m_g - (cyc - m_f - 1);
        e_exp = (cyc == m_f + 1 + m_g);
      end
    end
    check("rnd_rd", 32'(rnd_rd), 32'(e_rd));
    check("busy", 32'(busy), 32'(e_busy));
    check("expire", 32'(expire), 32'(e_exp));
    check("cur_gap", 32'(cur_gap), 32'(e_gap));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 70000 && busy; i++) tick();
    check("idle_bound", 32'(busy), 32'd0);
  endtask

`ifdef RAND_EXP_BACKOFF_EN
  task automatic run_gap(input logic rt, output logic [15:0] g);
    start = 1'b1; retry = rt;
    tick();
    start = 1'b0; retry = 1'b0;
    tick();
    g = cur_gap;
    wait_idle();
    tick();
  endtask
`endif

  initial begin
    int fetches;
    reset_n = 1'b0; start = 1'b0; retry = 1'b0; abort = 1'b0;
    min_gap = '0; gap_mask = '0; rnd_val = 32'h0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_gap", 32'(cur_gap), 32'd0);
    reset_n = 1'b1;
    tick();

    // Fixed gap of 4: fetch one cycle after start, expire six after.
    min_gap = 16'd4; gap_mask = 16'h0; start = 1'b1;
    tick();
    check("t1_rd_n1", 32'(rnd_rd), 32'd1);
    start = 1'b0;
    tick();
    check("t1_rd_n2", 32'(rnd_rd), 32'd0);
    check("t1_gap_n2", 32'(cur_gap), 32'd4);
    repeat (3) tick();
    check("t1_exp_n5", 32'(expire), 32'd0);
    tick();
    check("t1_exp_n6", 32'(expire), 32'd1);
    check("t1_busy_n6", 32'(busy), 32'd1);
    tick();
    check("t1_busy_n7", 32'(busy), 32'd0);

    // Masked random low byte.
    min_gap = 16'h0; gap_mask = 16'h00FF; rnd_val = 32'h1234_56A7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t2_gap", 32'(cur_gap), 32'h00A7);
    repeat (167) tick();
    check("t2_expire", 32'(expire), 32'd1);
    tick();

    // Saturation, then abort a few cycles into COUNT.
    min_gap = 16'hFFF0; gap_mask = 16'hFFFF; rnd_val = 32'hABCD_0100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t3_sat", 32'(cur_gap), 32'hFFFF);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_busy", 32'(busy), 32'd0);
    check("t4_abort_exp", 32'(expire), 32'd0);

    // start and abort together in IDLE: no fetch ever.
    start = 1'b1; abort = 1'b1;
    repeat (4) begin
      tick();
      check("t4_sa_rd", 32'(rnd_rd), 32'd0);
    end
    start = 1'b0; abort = 1'b0;
    tick();

    // start held: exactly one fetch per 5-cycle gap period.
    min_gap = 16'd2; gap_mask = 16'h0; start = 1'b1; fetches = 0;
    repeat (25) begin
      tick();
      fetches += int'(rnd_rd);
    end
    check("t5_fetches", 32'(fetches), 32'd5);
    start = 1'b0;
    wait_idle();
    tick();

    // Reset in the middle of COUNT.
    min_gap = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_gap", 32'(cur_gap), 32'd0);
    reset_n = 1'b1;
    tick();

`ifdef RAND_EXP_BACKOFF_EN
    begin
      logic [15:0] g;
      min_gap = 16'h0; gap_mask = 16'h0001; rnd_val = 32'h0000_FFFF;
      run_gap(1'b0, g); check("t6_base", 32'(g), 32'd1);
      run_gap(1'b1, g); check("t6_r1", 32'(g), 32'd3);
      run_gap(1'b1, g); check("t6_r2", 32'(g), 32'd7);
      run_gap(1'b1, g); check("t6_r3", 32'(g), 32'd15);
      run_gap(1'b0, g); check("t6_fresh", 32'(g), 32'd1);
    end
`endif

    // Randomized traffic; inputs change every cycle so late edits to
    // min_gap/gap_mask must not disturb a gap in progress.
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      start   = $urandom_range(0, 1) != 0;
      retry   = $urandom_range(0, 2) == 0;
      abort   = $urandom_range(0, 29) == 0;
      rnd_val = $urandom;
      if ($urandom_range(0, 49) == 0)
        min_gap = 16'hFFF0 | 16'($urandom_range(0, 15));
      else
        min_gap = 16'($urandom_range(0, 6));
`ifdef RAND_EXP_BACKOFF_EN
      gap_mask = 16'($urandom_range(0, 3));
`else
      case ($urandom_range(0, 4))
        0: gap_mask = 16'h0000;
        1: gap_mask = 16'h0001;
        2: gap_mask = 16'h0003;
        3: gap_mask = 16'h0007;
        default: gap_mask = 16'h000F;
      endcase
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
